fmul_pipe: RTL and testbench

//   Pipelined, parametrised IEEE-754-style floating-point multiplier. Next generation of the single-cycle FPU multiplier.

---
 rtl/fmul_pipe.sv | 189 ++++++++++++++++++
 tb/tb_fmul_pipe.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fmul_pipe.sv
// Three-stage pipelined floating-point multiplier with valid/ready handshake, tag pass-through and flush.
// Define FMUL_RNE_EN for round-to-nearest-even; otherwise results are truncated toward zero.
module fmul_pipe #(
  parameter int unsigned EW    = 8,
  parameter int unsigned MW    = 23,
  parameter int unsigned TAG_W = 5
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [EW+MW:0]    in_x1,
  input  logic [EW+MW:0]    in_x2,
  input  logic [TAG_W-1:0]  in_tag,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [EW+MW:0]    out_y,
  output logic [TAG_W-1:0]  out_tag
);

  localparam int unsigned FW = 1 + EW + MW;
  localparam int unsigned PW = 2 * MW + 2;
  localparam int unsigned XW = EW + 2;
`ifdef FMUL_RNE_EN
  localparam int unsigned PL = 0;
`else
  localparam int unsigned PL = MW;
`endif
  localparam int unsigned HW = PW - PL;

  localparam logic        [XW-1:0] BIAS   = XW'(2**(EW-1) - 1);
  localparam logic signed [XW-1:0] EMAX_X = XW'(2**EW - 1);
  localparam logic signed [XW-1:0] ZERO_X = '0;
  localparam logic signed [XW-1:0] ONE_X  = XW'(1);

  // Handshake: each stage loads when its successor is empty or draining
  logic ld_o, ld2, ld1;
  logic v1, v2;

  assign ld_o     = !out_valid || out_ready;
  assign ld2      = !v2 || ld_o;
  assign ld1      = !v1 || ld2;
  assign in_ready = ld1 && !flush;

  // Stage 1: unpack, exponent sum, mantissa product
  logic [EW-1:0]          e1_c, e2_c;
  logic                   s_c, zero_c, inf_c;
  logic signed [XW-1:0]   ey_c;
  logic [PW-1:PL]         prod_c;

  assign e1_c   = in_x1[FW-2:MW];
  assign e2_c   = in_x2[FW-2:MW];
  assign s_c    = in_x1[FW-1] ^ in_x2[FW-1];
  assign zero_c = (e1_c == '0) || (e2_c == '0);
  assign inf_c  = (e1_c == '1) || (e2_c == '1);
  assign ey_c   = signed'(XW'(e1_c) + XW'(e2_c) - BIAS);
  // Low product bits only feed rounding, so the truncating build keeps just the upper part
  assign prod_c = HW'((PW'({1'b1, in_x1[MW-1:0]}) * PW'({1'b1, in_x2[MW-1:0]})) >> PL);

  logic                   s1, zero1, inf1;
  logic signed [XW-1:0]   ey1;
  logic [PW-1:PL]         p1;
  logic [TAG_W-1:0]       tag1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v1    <= 1'b0;
      s1    <= 1'b0;
      zero1 <= 1'b0;
      inf1  <= 1'b0;
      ey1   <= '0;
      p1    <= '0;
      tag1  <= '0;
    end else if (flush) begin
      v1 <= 1'b0;
    end else if (ld1) begin
      v1 <= in_valid;
      if (in_valid) begin
        s1    <= s_c;
        zero1 <= zero_c;
        inf1  <= inf_c;
        ey1   <= ey_c;
        p1    <= prod_c;
        tag1  <= in_tag;
      end
    end
  end

  // Stage 2: normalise
  logic                   carry_c;
  logic [MW-1:0]          mn_c;
  logic signed [XW-1:0]   en_c;

  assign carry_c = p1[PW-1];
  assign mn_c    = carry_c ? p1[2*MW:MW+1] : p1[2*MW-1:MW];
  assign en_c    = carry_c ? ey1 + ONE_X : ey1;

`ifdef FMUL_RNE_EN
  logic g_c, st_c, g2, st2;
  assign g_c  = carry_c ? p1[MW] : p1[MW-1];
  assign st_c = carry_c ? |p1[MW-1:0] : |p1[MW-2:0];
`endif

  logic                   s2, zero2, inf2;
  logic signed [XW-1:0]   ey2;
  logic [MW-1:0]          m2;
  logic [TAG_W-1:0]       tag2;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v2    <= 1'b0;
      s2    <= 1'b0;
      zero2 <= 1'b0;
      inf2  <= 1'b0;
      ey2   <= '0;
      m2    <= '0;
      tag2  <= '0;
`ifdef FMUL_RNE_EN
      g2    <= 1'b0;
      st2   <= 1'b0;
`endif
    end else if (flush) begin
      v2 <= 1'b0;
    end else if (ld2) begin
      v2 <= v1;
      if (v1) begin
        s2    <= s1;
        zero2 <= zero1;
        inf2  <= inf1;
        ey2   <= en_c;
        m2    <= mn_c;
        tag2  <= tag1;
`ifdef FMUL_RNE_EN
        g2    <= g_c;
        st2   <= st_c;
`endif
      end
    end
  end

  // Stage 3: round, exception handling, pack
  logic [MW-1:0]          mf_c;
  logic signed [XW-1:0]   ef_c;
  logic                   uf_c, of_c;
  logic [FW-1:0]          y_c;

`ifdef FMUL_RNE_EN
  logic          inc_c;
  logic [MW:0]   mr_c;
  assign inc_c = g2 && (st2 || m2[0]);
  assign mr_c  = {1'b0, m2} + (MW+1)'(inc_c);
  // A carry out of the mantissa leaves it all-zero, i.e. 1.0 at the next exponent
  assign mf_c  = mr_c[MW-1:0];
  assign ef_c  = mr_c[MW] ? ey2 + ONE_X : ey2;
`else
  assign mf_c  = m2;
  assign ef_c  = ey2;
`endif

  assign uf_c = zero2 || (ef_c <= ZERO_X);
  assign of_c = inf2 || (ef_c >= EMAX_X);

  always_comb begin
    y_c = {s2, ef_c[EW-1:0], mf_c};
    if (uf_c) begin
      y_c = {s2, {(EW+MW){1'b0}}};
    end else if (of_c) begin
      y_c = {s2, {EW{1'b1}}, {MW{1'b0}}};
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      out_valid <= 1'b0;
      out_y     <= '0;
      out_tag   <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (ld_o) begin
      out_valid <= v2;
      if (v2) begin
        out_y   <= y_c;
        out_tag <= tag2;
      end
    end
  end

endmodule

// File: tb/tb_fmul_pipe.sv
// Scoreboard bench for fmul_pipe (EW=8, MW=23): directed cases, backpressure, flush and random traffic.
module tb_fmul_pipe;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_x1 = '0;
  logic [31:0] in_x2 = '0;
  logic [4:0]  in_tag = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_y;
  logic [4:0]  out_tag;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] y;
    logic [4:0]  tag;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  logic rnd_done = 1'b0;

  always #5 clk = ~clk;

  fmul_pipe #(.EW(8), .MW(23), .TAG_W(5)) dut (
    .clk(clk), .rstn(rstn), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x1(in_x1), .in_x2(in_x2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_y(out_y), .out_tag(out_tag)
  );

  // Reference product, written with integer arithmetic on the full 48-bit significand product
  function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
    int ea, eb, e, sh;
    logic s;
    longint unsigned p, mant;
`ifdef FMUL_RNE_EN
    longint unsigned rem, half;
`endif
    ea = int'(a[30:23]);
    eb = int'(b[30:23]);
    s  = a[31] ^ b[31];
    p  = 64'({1'b1, a[22:0]}) * 64'({1'b1, b[22:0]});
    e  = ea + eb - 127;
    if (p[47]) begin
      sh = 24;
      e  = e + 1;
    end else begin
      sh = 23;
    end
    mant = p >> sh;
`ifdef FMUL_RNE_EN
    rem  = p & ((64'd1 << sh) - 64'd1);
    half = 64'd1 << (sh - 1);
    if (rem > half || (rem == half && mant[0])) mant = mant + 64'd1;
    if (mant[24]) begin
      mant = mant >> 1;
      e    = e + 1;
    end
`endif
    if (ea == 0 || eb == 0 || e <= 0) return {s, 31'd0};
    if (ea == 255 || eb == 255 || e >= 255) return {s, 8'hFF, 23'd0};
    return {s, e[7:0], mant[22:0]};
  endfunction

  function automatic logic [31:0] rnd_op();
    logic [7:0] e;
    int r;
    r = int'($urandom_range(0, 9));
    if (r == 0)      e = 8'd0;
    else if (r == 1) e = 8'd255;
    else if (r < 4)  e = 8'($urandom_range(0, 255));
    else             e = 8'($urandom_range(100, 154));
    return {1'($urandom), e, 23'($urandom)};
  endfunction

  task automatic chk(input string name, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", name, obs, exp);
    end
  endtask

  // Offer one operand pair until accepted; expected result enters the scoreboard on acceptance
  task automatic put(input logic [31:0] a, input logic [31:0] b, input logic [4:0] t,
                     input logic [31:0] y);
    logic ok;
    exp_t e;
    ok = 1'b0;
    in_valid = 1'b1;
    in_x1 = a;
    in_x2 = b;
    in_tag = t;
    for (int n = 0; n < 300 && !ok; n++) begin
      @(negedge clk);
      ok = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checks++;
    assert (ok) else begin
      failures++;
      $error("FAIL accept_timeout observed=in_ready_low expected=accepted");
    end
    if (ok) begin
      e.y = y;
      e.tag = t;
      sb.push_back(e);
    end
  endtask

  task automatic drain();
    for (int n = 0; n < 200 && sb.size() != 0; n++) begin
      @(posedge clk);
      #1;
    end
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  // Output monitor: every transfer must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rstn && out_valid && out_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        failures++;
        $error("FAIL unexpected_out observed=%h tag=%h expected=no_output", out_y, out_tag);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        checks++;
        assert (out_y === mon_e.y) else begin
          failures++;
          $error("FAIL out_y observed=%h expected=%h", out_y, mon_e.y);
        end
        checks++;
        assert (out_tag === mon_e.tag) else begin
          failures++;
          $error("FAIL out_tag observed=%h expected=%h", out_tag, mon_e.tag);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic [31:0] bp_a[6];
  logic [31:0] bp_b[6];
  logic [31:0] ra, rb;

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_y", out_y, 32'd0);
    chk("rst_out_tag", 32'(out_tag), 32'd0);
    @(posedge clk);
    #1;
    rstn = 1'b1;
    out_ready = 1'b1;

    // 2*3 with latency check
    put(32'h40000000, 32'h40400000, 5'h03, 32'h40C00000);
    @(negedge clk);
    chk("lat_c1", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_c2", 32'(out_valid), 32'd0);
    @(negedge clk);
    chk("lat_c3", 32'(out_valid), 32'd1);
    @(posedge clk);
    #1;

    // Directed values, exceptions and rounding
    put(32'h3FC00000, 32'h3FC00000, 5'h1A, 32'h40100000);
    put(32'h7F000000, 32'h7F000000, 5'h04, 32'h7F800000);
    put(32'h00800000, 32'h00800000, 5'h05, 32'h00000000);
    put(32'h80000000, 32'h7F800000, 5'h06, 32'h80000000);
    put(32'hFF800000, 32'h3F800000, 5'h07, 32'hFF800000);
`ifdef FMUL_RNE_EN
    put(32'h3F800001, 32'h3FC00000, 5'h08, 32'h3FC00002);
`else
    put(32'h3F800001, 32'h3FC00000, 5'h08, 32'h3FC00001);
`endif
    drain();

    // Backpressure: six back-to-back inputs against a stalled consumer
    bp_a = '{32'h3F800000, 32'h40000000, 32'hC0A00000, 32'h3FC00000, 32'h41200000, 32'h3E800000};
    bp_b = '{32'h40400000, 32'h40800000, 32'h3F000000, 32'hC0000000, 32'h41200000, 32'h42000000};
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 6; i++) put(bp_a[i], bp_b[i], 5'(16 + i), ref_mul(bp_a[i], bp_b[i]));
      end
      begin
        repeat (5) @(negedge clk);
        chk("bp_in_ready", 32'(in_ready), 32'd0);
        chk("bp_out_valid", 32'(out_valid), 32'd1);
        chk("bp_y_hold_a", out_y, ref_mul(bp_a[0], bp_b[0]));
        repeat (5) @(negedge clk);
        chk("bp_y_hold_b", out_y, ref_mul(bp_a[0], bp_b[0]));
        chk("bp_tag_hold", 32'(out_tag), 32'd16);
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Flush with three in flight and a simultaneous new request
    out_ready = 1'b0;
    put(32'h40000000, 32'h40000000, 5'h09, ref_mul(32'h40000000, 32'h40000000));
    put(32'h40400000, 32'h40000000, 5'h0A, ref_mul(32'h40400000, 32'h40000000));
    put(32'h40800000, 32'h40000000, 5'h0B, ref_mul(32'h40800000, 32'h40000000));
    in_valid = 1'b1;
    in_x1 = 32'h3F800000;
    in_x2 = 32'h3F800000;
    in_tag = 5'h0C;
    flush = 1'b1;
    @(negedge clk);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk);
    #1;
    flush = 1'b0;
    in_valid = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("flush_quiet", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;

    // Random traffic with random consumer stalls
    fork
      begin
        for (int i = 0; i < 1000; i++) begin
          ra = rnd_op();
          rb = rnd_op();
          put(ra, rb, 5'(i), ref_mul(ra, rb));
          repeat ($urandom_range(0, 1)) begin
            @(posedge clk);
            #1;
          end
        end
        rnd_done = 1'b1;
      end
      begin
        while (!rnd_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 2) != 0);
        end
      end
    join
    out_ready = 1'b1;
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
